// File: rtl/sobel_ctrl.sv
// Sobel front-end control: tracks pixel position in a vs/dv video stream, drives the line-buffer
// write port, flags complete 3x3 windows and applies requested modes at frame start.
module sobel_ctrl #(
    parameter int unsigned ADDR_W   = 11,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dv_i,
    input  logic              hs_i,
    input  logic              vs_i,
    input  logic [1:0]        mode_req,
    input  logic              mode_req_valid,
    output logic [ADDR_W-1:0] col,
    output logic [ADDR_W-1:0] row,
    output logic              lb_wr_en,
    output logic [ADDR_W-1:0] lb_addr,
    output logic              win_valid,
    output logic              border,
    output logic [1:0]        mode_act,
    output logic              mode_ack,
    output logic              frame_start,
    output logic [ADDR_W-1:0] line_width,
    output logic [ADDR_W-1:0] frame_height,
    output logic              err_geom
);
    localparam logic [ADDR_W-1:0] CNT_MAX    = {ADDR_W{1'b1}};
    localparam logic [1:0]        MODE_SOBEL = 2'd1;
    localparam logic [1:0]        MODE_RSVD  = 2'd3;

    typedef enum logic [1:0] {IDLE, WAIT_DATA, IN_LINE, H_BLANK} state_t;

    state_t            state_q, state_d;
    logic              vs_d_q, hs_d_q, dv_d_q;
    logic [ADDR_W-1:0] col_q, col_d, row_q, row_d;
    logic [ADDR_W-1:0] lw_q, lw_d, fh_q, fh_d;
    logic              wr_q, wr_d, win_q, win_d, border_q, border_d;
    logic              fs_q, fs_d, ack_q, ack_d, err_q, err_d;
    logic [1:0]        mode_q, mode_d, pend_mode_q, pend_mode_d;
    logic              pend_q, pend_d;
    logic              vs_edge, hs_edge, req_ok, pix_d;
    logic              unused_hs;

    assign vs_edge = (vs_i == SYNC_POL) && (vs_d_q != SYNC_POL);
    assign hs_edge = (hs_i == SYNC_POL) && (hs_d_q != SYNC_POL);
    // hs is only tracked; line boundaries are taken from dv
    assign unused_hs = hs_edge;
    assign req_ok  = mode_req_valid && (mode_req != MODE_RSVD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vs_d_q      <= ~SYNC_POL;
            hs_d_q      <= ~SYNC_POL;
            dv_d_q      <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            lw_q        <= '0;
            fh_q        <= '0;
            wr_q        <= 1'b0;
            win_q       <= 1'b0;
            border_q    <= 1'b0;
            fs_q        <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            mode_q      <= MODE_SOBEL;
            pend_mode_q <= MODE_SOBEL;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_d_q      <= vs_i;
            hs_d_q      <= hs_i;
            dv_d_q      <= dv_i;
            col_q       <= col_d;
            row_q       <= row_d;
            lw_q        <= lw_d;
            fh_q        <= fh_d;
            wr_q        <= wr_d;
            win_q       <= win_d;
            border_q    <= border_d;
            fs_q        <= fs_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            mode_q      <= mode_d;
            pend_mode_q <= pend_mode_d;
            pend_q      <= pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        lw_d        = lw_q;
        fh_d        = fh_q;
        err_d       = err_q;
        fs_d        = 1'b0;
        ack_d       = 1'b0;
        mode_d      = mode_q;
        pend_d      = pend_q;
        pend_mode_d = pend_mode_q;
        pix_d       = 1'b0;

        if (req_ok) begin
            pend_d      = 1'b1;
            pend_mode_d = mode_req;
        end

        if (vs_edge) begin
            state_d = WAIT_DATA;
            fs_d    = 1'b1;
            fh_d    = row_q;
            row_d   = '0;
            col_d   = '0;
            err_d   = 1'b0;
            // a request arriving on the same cycle stays pending for the next frame
            if (pend_q) begin
                mode_d = pend_mode_q;
                ack_d  = 1'b1;
                pend_d = req_ok;
            end
        end else begin
            case (state_q)
                IDLE: ;
                WAIT_DATA, H_BLANK: begin
                    if (dv_i) begin
                        state_d = IN_LINE;
                        col_d   = '0;
                        pix_d   = 1'b1;
                    end
                end
                IN_LINE: begin
                    if (dv_i) begin
                        if (col_q == CNT_MAX) begin
                            err_d = 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                            pix_d = 1'b1;
                        end
                    end else if (dv_d_q) begin
                        state_d = H_BLANK;
                        col_d   = '0;
                        if (row_q != CNT_MAX) row_d = row_q + 1'b1;
                        if (row_q == '0) lw_d = col_q + 1'b1;
                        else if ((col_q + 1'b1) != lw_q) err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        wr_d     = pix_d;
        win_d    = pix_d && (row_d >= ADDR_W'(2)) && (col_d >= ADDR_W'(2));
        border_d = win_d && ((row_d == ADDR_W'(2)) || (col_d == ADDR_W'(2)) ||
                             ((lw_q != '0) && (col_d == lw_q - 1'b1)));
    end

    assign col          = col_q;
    assign row          = row_q;
    assign lb_wr_en     = wr_q;
    assign lb_addr      = col_q;
    assign win_valid    = win_q;
    assign border       = border_q;
    assign mode_act     = mode_q;
    assign mode_ack     = ack_q;
    assign frame_start  = fs_q;
    assign line_width   = lw_q;
    assign frame_height = fh_q;
    assign err_geom     = err_q;
endmodule
